mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_select.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instr/data memory port arbiter.
// Holds the FSM state enum, the owner enum and parameter defaults.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int STREAK_MAX_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        WAIT_RSP
    } arb_state_e;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Grant decision between fetch and load/store plus anti-starvation streak.
// Ports: clk, reset, idle, instr_req, data_req -> grant_valid, grant_owner.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle,
    input  logic       instr_req,
    input  logic       data_req,
    output logic       grant_valid,
    output arb_owner_e grant_owner
);

    // Sized so the counter can hold STREAK_MAX, never zero-width.
    localparam int SW = $clog2(STREAK_MAX + 2);

    logic [SW-1:0] streak;
    logic          starve;

    // Fetch has waited through the allowed number of data wins.
    assign starve = instr_req && (streak == SW'(STREAK_MAX));

    always_comb begin
        grant_valid = idle && (instr_req || data_req);
        grant_owner = (data_req && !starve) ? OWN_DATA : OWN_INSTR;
    end

    // Only IDLE edges are decision points; other edges leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (idle) begin
            if (!instr_req || grant_owner == OWN_INSTR) begin
                streak <= '0;
            end else if (streak != SW'(STREAK_MAX)) begin
                streak <= streak + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Ports: instr_* fetch side, data_* load/store side, mem_* shared port.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_req_in,
    input  logic [ADDR_W-1:0]   instr_addr_in,
    input  logic                instr_flush_in,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    input  logic                data_req_in,
    input  logic                data_we_in,
    input  logic [DATA_W/8-1:0] data_be_in,
    input  logic [ADDR_W-1:0]   data_addr_in,
    input  logic [DATA_W-1:0]   data_wdata_in,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                mem_req_out,
    output logic                mem_we_out,
    output logic [DATA_W/8-1:0] mem_be_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic [DATA_W-1:0]   mem_wdata_out,
    input  logic                mem_gnt_in,
    input  logic                mem_rvalid_in,
    input  logic [DATA_W-1:0]   mem_rdata_in,
    output logic                busy_out
);

    arb_state_e state;
    arb_owner_e owner;
    logic       discard;
    logic       idle;
    logic       grant_valid;
    arb_owner_e grant_owner;
    logic       rsp_hit;
    logic       kill_fetch;

    assign idle = (state == IDLE);

    mem_arb_select #(
        .STREAK_MAX (STREAK_MAX)
    ) u_select (
        .clk         (clk),
        .reset       (reset),
        .idle        (idle),
        .instr_req   (instr_req_in),
        .data_req    (data_req_in),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign kill_fetch = (owner == OWN_INSTR) && instr_flush_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWN_INSTR;
            discard       <= 1'b0;
            instr_gnt_o   <= 1'b0;
            data_gnt_o    <= 1'b0;
            mem_req_out   <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_be_out    <= '0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            busy_out      <= 1'b0;
        end else begin
            instr_gnt_o <= 1'b0;
            data_gnt_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state       <= MEM_REQ;
                        busy_out    <= 1'b1;
                        owner       <= grant_owner;
                        discard     <= 1'b0;
                        mem_req_out <= 1'b1;
                        if (grant_owner == OWN_DATA) begin
                            data_gnt_o    <= 1'b1;
                            mem_we_out    <= data_we_in;
                            mem_be_out    <= data_be_in;
                            mem_addr_out  <= data_addr_in;
                            mem_wdata_out <= data_wdata_in;
                        end else begin
                            instr_gnt_o   <= 1'b1;
                            mem_we_out    <= 1'b0;
                            mem_be_out    <= '1;
                            mem_addr_out  <= instr_addr_in;
                            mem_wdata_out <= '0;
                        end
                    end
                end
                MEM_REQ: begin
                    if (kill_fetch) discard <= 1'b1;
                    if (mem_gnt_in) begin
                        state       <= WAIT_RSP;
                        mem_req_out <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    if (kill_fetch) discard <= 1'b1;
                    if (mem_rvalid_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                        discard  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

    // Response is forwarded combinationally; a flush in the response
    // cycle itself still suppresses the fetch.
    assign rsp_hit = (state == WAIT_RSP) && mem_rvalid_in;

    always_comb begin
        instr_rvalid_o = rsp_hit && (owner == OWN_INSTR)
                         && !discard && !instr_flush_in;
        data_rvalid_o  = rsp_hit && (owner == OWN_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_in : '0;
        data_rdata_o   = data_rvalid_o ? mem_rdata_in : '0;
    end

endmodule
